euclid_step_ctrl: RTL
=====================

Name: euclid_step_ctrl

Overview:
- Sequencer for the modified-Euclidean key-equation solver in the RS decoder.
- Drives the load/hold select of the 8-bit feedback register bank, so syndromes load serially and then hold between iterations.
- Tracks deg(R) and deg(Q), and issues one polynomial operation per iteration to the Galois-field datapath.
- Terminates when deg(R) < T (success) or the step budget is exhausted (failure).

Parameters:
- T, 8, error-correction capability; 2T syndromes per codeword.
- MAX_STEP, 2*T, iteration limit before failure is declared.
- DW, $clog2(2*T+1), width of the degree and step counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs are cleared immediately.
- start  in  1  begin a new codeword; sampled only in IDLE, ignored otherwise.
- lead_r_zero  in  1  datapath flag: the leading coefficient of R is zero; sampled in EVAL.
- reg_hold  out  1  select for the feedback register mux. 1 = hold (feedback path), 0 = load or update from the datapath.
- load_idx  out  $clog2(2*T)  syndrome index being loaded during LOAD.
- op  out  2  datapath operation: 00 NOP, 01 REDUCE, 10 SWAP_REDUCE, 11 SHIFT.
- busy  out  1  high in every state except IDLE.
- deg_r  out  DW  current degree of R.
- deg_q  out  DW  current degree of Q.
- step_cnt  out  DW  iterations completed.
- done  out  1  one-cycle pulse when the run ends.
- fail  out  1  valid with done; stays stable until the next start.

Behaviour:
- Reset values: reg_hold=1, load_idx=0, op=00, busy=0, deg_r=2T-1, deg_q=2T, step_cnt=0, done=0, fail=0, state=IDLE.
- Reset asserted mid-run aborts immediately to the reset values; no done pulse is produced.
- IDLE:
  - reg_hold=1, op=00.
  - start=1 → LOAD on the next edge; load_idx=0, deg_r=2T-1, deg_q=2T, step_cnt=0, fail=0.
- LOAD:
  - Lasts exactly 2T cycles; reg_hold=0; load_idx counts 0..2T-1.
  - At load_idx=2T-1 → EVAL.
- EVAL (1 cycle): reg_hold=1, op=00; registers the decision from lead_r_zero, deg_r and deg_q.
- EXEC (1 cycle): reg_hold=0, op=registered decision; step_cnt increments by 1. Degree updates take effect at the end of EXEC:
  - lead_r_zero=1: op=SHIFT, deg_r-=1, deg_q unchanged.
  - lead_r_zero=0 and deg_r<deg_q: op=SWAP_REDUCE, deg_r=deg_q-1, deg_q=old deg_r.
  - lead_r_zero=0 and deg_r>=deg_q: op=REDUCE, deg_r-=1.
- CHECK (1 cycle): reg_hold=1, op=00. Checks are evaluated in this order:
  - deg_r<T → DONE with fail=0. The degree check takes priority over the step limit.
  - else step_cnt==MAX_STEP → DONE with fail=1.
  - else → EVAL.
- DONE (1 cycle): done=1, busy=1 → IDLE.
- Degree arithmetic:
  - Unsigned, DW bits.
  - deg_r never drops below T-1, because the run stops first, so no underflow guard is needed.
  - Degrees and step_cnt hold their final values in IDLE until the next start.
- Timing:
  - Each iteration takes 3 cycles.
  - The done pulse occurs 2T + 3·steps + 1 cycles after the edge that samples start.
- start held high through DONE: a new run begins only after IDLE is re-entered, i.e. the cycle after DONE.

Test Plan:
- Reset: assert reset mid-LOAD.
  - Outputs equal reset values asynchronously, before the next clock edge.
  - After release, the block idles until start.
- T=8, start pulse: reg_hold=0 for exactly 16 cycles with load_idx 0..15, then EVAL with reg_hold=1.
- T=8, lead_r_zero=0 throughout:
  - Ops alternate SWAP_REDUCE/REDUCE; (deg_r, deg_q) go (15,15), (14,15), (14,14), ...
  - deg_r=7 after step 16; done at cycle 65 with fail=0.
- T=8, lead_r_zero=1 throughout: op=SHIFT every step; deg_r reaches 7 after 8 steps; done at cycle 41 with fail=0, deg_q=16.
- T=8, MAX_STEP=8, lead_r_zero=0: after 8 steps deg_r=11≥8, so done with fail=1 and step_cnt=8.
- Start asserted while busy: ignored, with no disturbance to degrees or timing. Start held high through DONE: the second run's LOAD begins the cycle after IDLE is entered.

Source files
------------

// File: rtl/euclid_step_ctrl.sv
// rtl/euclid_step_ctrl.sv - sequencer for the modified-Euclidean key-equation solver
//
// Loads 2T syndromes serially into the feedback register bank, then runs
// EVAL -> EXEC -> CHECK iterations. Each iteration issues one polynomial
// operation to the GF datapath and tracks deg(R) and deg(Q). The run ends
// when deg(R) < T (success) or after MAX_STEP iterations (failure).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   start        begin a new codeword (sampled only in IDLE)
//   lead_r_zero  datapath flag: leading coefficient of R is zero (sampled in EVAL)
//   reg_hold     feedback mux select: 1 = hold, 0 = load/update
//   load_idx     syndrome index being loaded during LOAD
//   op           datapath op: 00 NOP, 01 REDUCE, 10 SWAP_REDUCE, 11 SHIFT
//   busy         high in every state except IDLE
//   deg_r        current degree of R
//   deg_q        current degree of Q
//   step_cnt     iterations completed
//   done         one-cycle pulse when the run ends
//   fail         run outcome, valid with done, stable until next start
module euclid_step_ctrl #(
  parameter int T        = 8,
  parameter int MAX_STEP = 2 * T,
  parameter int DW       = $clog2(2 * T + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    lead_r_zero,
  output logic                    reg_hold,
  output logic [$clog2(2*T)-1:0]  load_idx,
  output logic [1:0]              op,
  output logic                    busy,
  output logic [DW-1:0]           deg_r,
  output logic [DW-1:0]           deg_q,
  output logic [DW-1:0]           step_cnt,
  output logic                    done,
  output logic                    fail
);

  localparam int LW = $clog2(2 * T);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_REDUCE = 2'b01;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_SHIFT  = 2'b11;

  localparam logic [LW-1:0] LOAD_FIRST = '0;
  localparam logic [LW-1:0] LOAD_LAST  = LW'(2 * T - 1);
  localparam logic [LW-1:0] LOAD_ONE   = LW'(1);

  localparam logic [DW-1:0] DEG_R_INIT = DW'(2 * T - 1);
  localparam logic [DW-1:0] DEG_Q_INIT = DW'(2 * T);
  localparam logic [DW-1:0] DEG_T      = DW'(T);
  localparam logic [DW-1:0] STEP_LIMIT = DW'(MAX_STEP);
  localparam logic [DW-1:0] DW_ONE     = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_EXEC,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;

  // All outputs are registered: each transition sets the output values
  // that belong to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      reg_hold <= 1'b1;
      load_idx <= LOAD_FIRST;
      op       <= OP_NOP;
      busy     <= 1'b0;
      deg_r    <= DEG_R_INIT;
      deg_q    <= DEG_Q_INIT;
      step_cnt <= '0;
      done     <= 1'b0;
      fail     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          reg_hold <= 1'b1;
          op       <= OP_NOP;
          busy     <= 1'b0;
          if (start) begin
            state    <= S_LOAD;
            reg_hold <= 1'b0;
            busy     <= 1'b1;
            load_idx <= LOAD_FIRST;
            deg_r    <= DEG_R_INIT;
            deg_q    <= DEG_Q_INIT;
            step_cnt <= '0;
            fail     <= 1'b0;
          end
        end

        S_LOAD: begin
          if (load_idx == LOAD_LAST) begin
            state    <= S_EVAL;
            reg_hold <= 1'b1;
            load_idx <= LOAD_FIRST;
          end else begin
            load_idx <= load_idx + LOAD_ONE;
          end
        end

        // The op register doubles as the registered decision consumed in EXEC.
        S_EVAL: begin
          state    <= S_EXEC;
          reg_hold <= 1'b0;
          if (lead_r_zero) begin
            op <= OP_SHIFT;
          end else if (deg_r < deg_q) begin
            op <= OP_SWAP;
          end else begin
            op <= OP_REDUCE;
          end
        end

        // deg_r cannot underflow: the run stops once it reaches T-1.
        S_EXEC: begin
          state    <= S_CHECK;
          reg_hold <= 1'b1;
          op       <= OP_NOP;
          step_cnt <= step_cnt + DW_ONE;
          if (op == OP_SWAP) begin
            deg_r <= deg_q - DW_ONE;
            deg_q <= deg_r;
          end else begin
            deg_r <= deg_r - DW_ONE;
          end
        end

        // Degree success wins over the step limit when both hold.
        S_CHECK: begin
          if (deg_r < DEG_T) begin
            state <= S_DONE;
            done  <= 1'b1;
            fail  <= 1'b0;
          end else if (step_cnt == STEP_LIMIT) begin
            state <= S_DONE;
            done  <= 1'b1;
            fail  <= 1'b1;
          end else begin
            state <= S_EVAL;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          reg_hold <= 1'b1;
          op       <= OP_NOP;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
